// File: rtl/johnson_ptr_counter_pkg.sv
// Shared definitions for the Johnson-pointer FIFO path: the legality rule, the
// state-to-code mapping and the pointer update operations.
package johnson_ptr_counter_pkg;

  localparam int JC_MAX_W = 64;

  typedef logic [JC_MAX_W-1:0] jc_word_t;

  typedef enum logic [1:0] {
    PTR_HOLD  = 2'd0,
    PTR_CLEAR = 2'd1,
    PTR_INC   = 2'd2
  } ptr_op_e;

  // A Johnson code has at most one boundary between its run of ones and zeros.
  function automatic logic jc_is_legal(input jc_word_t code, input int jcw);
    int transitions;
    transitions = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i + 1 < jcw) && (code[i] != code[i+1])) begin
        transitions = transitions + 1;
      end else begin
        transitions = transitions + 0;
      end
    end
    return (transitions <= 1);
  endfunction

  function automatic jc_word_t jc_for_state(input int k, input int jcw);
    jc_word_t code;
    code = '0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < jcw) begin
        code[i] = (k < jcw) ? (i < k) : (i >= k - jcw);
      end else begin
        code[i] = 1'b0;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/johnson_legal_check.sv
// Combinational Johnson-code legality check for a JCW-bit code.
module johnson_legal_check
  import johnson_ptr_counter_pkg::*;
#(
  parameter int JCW = 8
) (
  input  logic [JCW-1:0] i_code,
  output logic           o_legal
);

  jc_word_t code_ext_s;

  // Zero-extend into the package word; bits above JCW are never inspected.
  always_comb begin
    code_ext_s             = '0;
    code_ext_s[JCW-1:0]    = i_code;
    o_legal                = jc_is_legal(code_ext_s, JCW);
  end

endmodule

// File: rtl/johnson_ptr_counter.sv
// Johnson FIFO pointer with a parallel binary pointer, peer compare for
// empty/full, and legality monitoring of both the peer and own code.
module johnson_ptr_counter
  import johnson_ptr_counter_pkg::*;
#(
  parameter int JCW   = 8,
  parameter int WIDTH = $clog2(JCW) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clear,
  input  logic [JCW-1:0]   i_peer_jc,
  output logic [JCW-1:0]   o_jc,
  output logic [WIDTH-1:0] o_bin,
  output logic [WIDTH-1:0] ow_bin_next,
  output logic             ow_equal,
  output logic             ow_opposite,
  output logic             ow_peer_illegal,
  output logic             o_self_err
);

  localparam int IDX_W = WIDTH - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(JCW - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [JCW-1:0]   jc_q, jc_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             self_err_q, self_err_d;
  logic [WIDTH-1:0] bin_inc_s;
  logic             peer_legal_s;
  logic             self_legal_s;
  ptr_op_e          op_s;

  johnson_legal_check #(.JCW(JCW)) u_peer_check (
    .i_code  (i_peer_jc),
    .o_legal (peer_legal_s)
  );

  johnson_legal_check #(.JCW(JCW)) u_self_check (
    .i_code  (jc_q),
    .o_legal (self_legal_s)
  );

  // Index wraps at JCW (not a power of two in general); the wrap bit flips there.
  always_comb begin
    if (bin_q[IDX_W-1:0] == IDX_LAST) begin
      bin_inc_s = {~bin_q[WIDTH-1], {IDX_W{1'b0}}};
    end else begin
      bin_inc_s = {bin_q[WIDTH-1], bin_q[IDX_W-1:0] + IDX_ONE};
    end
  end

  // Operation select: clear beats increment beats hold.
  always_comb begin
    if (i_clear) begin
      op_s = PTR_CLEAR;
    end else if (i_inc) begin
      op_s = PTR_INC;
    end else begin
      op_s = PTR_HOLD;
    end
  end

  // Next state: both pointers move from the same operation so they stay in step.
  always_comb begin
    jc_d       = jc_q;
    bin_d      = bin_q;
    self_err_d = self_err_q | ~self_legal_s;
    case (op_s)
      PTR_CLEAR: begin
        jc_d       = '0;
        bin_d      = '0;
        self_err_d = 1'b0;
      end
      PTR_INC: begin
        jc_d  = {jc_q[JCW-2:0], ~jc_q[JCW-1]};
        bin_d = bin_inc_s;
      end
      PTR_HOLD: begin
        jc_d  = jc_q;
        bin_d = bin_q;
      end
      default: begin
        jc_d       = '0;
        bin_d      = '0;
        self_err_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      jc_q       <= '0;
      bin_q      <= '0;
      self_err_q <= 1'b0;
    end else begin
      jc_q       <= jc_d;
      bin_q      <= bin_d;
      self_err_q <= self_err_d;
    end
  end

  // States k and k+JCW are bitwise complements, so "opposite" means full.
  always_comb begin
    o_jc            = jc_q;
    o_bin           = bin_q;
    o_self_err      = self_err_q;
    ow_bin_next     = bin_inc_s;
    ow_equal        = (jc_q == i_peer_jc);
    ow_opposite     = (jc_q == ~i_peer_jc);
    ow_peer_illegal = ~peer_legal_s;
  end

endmodule

// File: doc/johnson_ptr_counter.md
# johnson_ptr_counter

Johnson-code FIFO pointer counter: the encode/generate end of the Johnson-pointer path, producing the code that the downstream Johnson-to-binary decoder consumes. It advances a JCW-bit Johnson register and a parallel binary pointer with wrap bit on each increment. It compares its own pointer against an already-synchronized peer Johnson pointer to flag empty (equal) and full (opposite) conditions. It also flags corrupted codes. It sits on the write or read side of a Johnson-pointer async FIFO, with one instance per clock domain.

## Interface
- JCW, 8: Johnson code width, equal to FIFO depth; must be ≥2. The pointer cycles through 2·JCW states.
- WIDTH, $clog2(JCW)+1: binary pointer width; the MSB is the wrap bit.
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_inc  in  1  advance pointer one state.
- i_clear  in  1  synchronous return to state 0.
- i_peer_jc  in  JCW  peer Johnson pointer, already synchronized into i_clk.
- o_jc  out  JCW  registered Johnson pointer; changes by exactly one bit per step.
- o_bin  out  WIDTH  registered binary pointer; the MSB is the wrap bit and the low bits are the index.
- ow_bin_next  out  WIDTH  combinational value o_bin would take if i_inc=1 this cycle (RAM address lookahead).
- ow_equal  out  1  o_jc == i_peer_jc.
- ow_opposite  out  1  o_jc == ~i_peer_jc.
- ow_peer_illegal  out  1  i_peer_jc is not a legal Johnson code.
- o_self_err  out  1  sticky flag; o_jc was observed illegal.

## Operation
- Encoding: state k (0..2·JCW−1).
  - For k<JCW, the code has k ones in the low bits (0…01…1).
  - For k≥JCW, the code is all ones with (k−JCW) low bits cleared.
  - Binary: o_bin[WIDTH-1] = (k≥JCW) = o_jc[JCW-1]; o_bin[WIDTH-2:0] = k mod JCW.
- Increment: o_jc ← {o_jc[JCW-2:0], ~o_jc[JCW-1]}.
  - The low bits of o_bin increment and wrap from JCW−1 to 0.
  - The wrap bit toggles on that same wrap.
  - Non-power-of-2 JCW is supported; the index wraps at JCW, not 2^(WIDTH-1).
- Priority: i_rst > i_clear > i_inc > hold.
- Compare: states k and k+JCW are bitwise complements.
  - ow_equal=1 means identical pointers (empty when used on the read side).
  - ow_opposite=1 means same index with opposite wrap (full when used on the write side).
  - Both are purely combinational from o_jc and i_peer_jc.
- Legality: a code is legal iff the count of adjacent-bit transitions (bit i ≠ bit i+1, i=0..JCW−2) is ≤1.
  - ow_peer_illegal is computed on i_peer_jc, combinationally.
  - o_self_err sets on the cycle after o_jc becomes illegal.
  - o_self_err is cleared only by i_rst or i_clear.
- o_jc and o_bin must always represent the same k. They are updated together from the same enable.

## Timing
- Reset: o_jc=0, o_bin=0, o_self_err=0.
  - After reset, ow_bin_next=1.
  - ow_equal/ow_opposite follow i_peer_jc combinationally.
- Latency: i_inc sampled at edge n changes o_jc/o_bin after edge n.
  - ow_bin_next equals the post-edge o_bin whenever i_inc=1.
- i_inc held high advances one state per cycle with no bubbles. A full cycle is 2·JCW increments back to 0.
- i_clear with i_inc in the same cycle: the result is state 0, and the increment is dropped.
- i_rst asserted mid-sequence: the next edge gives state 0 regardless of i_inc/i_clear.
- Compare outputs have zero-cycle latency from i_peer_jc changes. The peer synchronizer is outside this block.

## Structure
- Shared package: a Johnson-legality function (transition count ≤1), and a function that returns the Johnson code for state k, used by benches and the decoder side.
- Sub-module johnson_legal_check (combinational, parameter JCW), instantiated twice: peer and self.
- No other sub-modules; the binary pointer is an in-block counter.

## Test plan
- Reset and hold: assert i_rst for 2 cycles, then JCW=4, i_inc=0 → o_jc=4'b0000, o_bin=3'b000, ow_bin_next=3'b001, o_self_err=0.
- Full sweep: JCW=4, i_inc=1 for 8 cycles.
  - o_jc must follow 0001,0011,0111,1111,1110,1100,1000,0000.
  - o_bin must follow 001,010,011,100,101,110,111,000.
  - Check one bit changing per step.
- Non-power-of-2: JCW=5, 10 increments → o_bin index wraps 4→0 with wrap bit set at step 5 (o_jc=5'b11111, o_bin=4'b1000), and both return to 0 at step 10.
- Compare: JCW=4, o_jc=0011.
  - Peer=0011 → ow_equal=1.
  - Peer=1100 → ow_opposite=1.
  - Peer=0111 → both 0.
- Legality: peer=0101 → ow_peer_illegal=1; peer=1000 → 0.
  - Force o_jc=0110 → o_self_err=1 the next cycle, sticky until i_clear.
- Priority: i_clear=1 with i_inc=1 at state 5 → state 0 next cycle. i_rst=1 with i_clear=0 and i_inc=1 → state 0.
